lsu_controller: RTL

Multi-cycle load/store sequencer between the RV32 core datapath and a handshaked data-memory bus. It accepts one memory instruction at a time, using the decoder's `Load[2:0]` and `Store[1:0]` encodings. It drives byte-lane write strobes, holds the core in stall until the access completes, and returns a sign- or zero-extended load result. It also flags misaligned, illegal and timed-out accesses.

---
 rtl/lsu_controller.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_controller.sv
// lsu_controller
//   Load/store sequencer between the RV32 core datapath and a handshaked
//   data-memory bus. One memory instruction is in flight at a time. The block
//   drives byte-lane strobes and stalls the core until the access completes.
//   It returns sign/zero-extended load data and flags misaligned, illegal and
//   timed-out accesses.
//
//   Ports
//     clk, reset              : single clock, synchronous active-high reset
//     start, is_store         : core presents a load (0) or store (1)
//     Load[2:0], Store[1:0]   : decoder size/sign encodings
//     addr, wdata             : effective byte address and rs2 value
//     stall                   : freezes PC / pipeline registers (combinational)
//     done, err               : one-cycle completion / error-completion pulses
//     rdata                   : extended load data, held until the next done
//     bus_req/we/addr/wdata/be: bus request side, stable until bus_gnt
//     bus_gnt                 : request accepted this cycle
//     bus_rvalid, bus_rdata   : read response
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  Load,
    input  logic [1:0]  Store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT_R = 2'd2, S_DONE = 2'd3} state_t;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

    // Byte-lane strobes for a store of the given size at the given lane.
    function automatic logic [3:0] store_be(input size_t size, input logic [1:0] lane);
        case (size)
            SZ_B:    store_be = 4'b0001 << lane;
            SZ_H:    store_be = lane[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate store data so every selected lane carries the right bytes.
    function automatic logic [31:0] store_data(input size_t size, input logic [31:0] wd);
        case (size)
            SZ_B:    store_data = {4{wd[7:0]}};
            SZ_H:    store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    // Select the addressed byte/half of a read word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] d, input size_t size,
                                                 input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (size)
            SZ_B:    load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extract = d;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic        is_store_q, is_store_d;
    size_t       size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;

    size_t       req_size_s;
    logic        req_uns_s;
    logic        req_illegal_s;
    logic        req_misaligned_s;
    logic        timeout_s;

    // Decode the incoming instruction into size/sign and legality.
    always_comb begin
        req_size_s       = SZ_W;
        req_uns_s        = 1'b0;
        req_illegal_s    = 1'b0;
        req_misaligned_s = 1'b0;
        if (is_store) begin
            case (Store)
                2'b00:   req_size_s = SZ_B;
                2'b01:   req_size_s = SZ_H;
                2'b10:   req_size_s = SZ_W;
                default: req_illegal_s = 1'b1;
            endcase
        end else begin
            case (Load)
                3'b000:  req_size_s = SZ_B;
                3'b001:  req_size_s = SZ_H;
                3'b010:  req_size_s = SZ_W;
                3'b011:  begin req_size_s = SZ_B; req_uns_s = 1'b1; end
                3'b100:  begin req_size_s = SZ_H; req_uns_s = 1'b1; end
                default: req_illegal_s = 1'b1;
            endcase
        end
        case (req_size_s)
            SZ_H:    req_misaligned_s = addr[0];
            SZ_W:    req_misaligned_s = (addr[1:0] != 2'b00);
            default: req_misaligned_s = 1'b0;
        endcase
    end

    // Timeout fires in the cycle the counter would reach the limit, so it
    // beats a grant or response arriving in that same cycle.
    assign cnt_inc_s = cnt_q + CNT_W'(1);
    assign timeout_s = (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES));

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    size_d     = req_size_s;
                    uns_d      = req_uns_s;
                    lane_d     = addr[1:0];
                    if (req_illegal_s || req_misaligned_s) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = {CNT_W{1'b0}};
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = is_store ? store_be(req_size_s, addr[1:0]) : 4'b1111;
                        bus_wdata_d = is_store ? store_data(req_size_s, wdata) : wdata;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc_s;
                if (timeout_s) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = 32'd0;
                    bus_req_d = 1'b0;
                end else if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = is_store_q ? S_DONE : S_WAIT_R;
                    done_d    = is_store_q;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT_R: begin
                cnt_d = cnt_inc_s;
                if (timeout_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else if (bus_rvalid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = load_extract(bus_rdata, size_q, uns_q, lane_q);
                end else begin
                    state_d = S_WAIT_R;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            is_store_q  <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            lane_q      <= 2'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
        end
    end

    // The core may advance on the done cycle, so DONE does not stall.
    assign stall     = ((state_q == S_IDLE) && start) || (state_q == S_REQ) || (state_q == S_WAIT_R);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

endmodule
